// File: rtl/key_cursor_ctrl.sv
// key_cursor_ctrl: push-button cursor controller.
//   Debounces NUM_KEYS active-low keys and generates press/hold-to-repeat step
//   events. These events drive bounded X/Y position counters used by the
//   display overlay/crosshair path.
//   Keys are numbered from 1, and key n is bit n-1 of iKEY:
//     key 1 = iKEY[0] increments X, key 2 = iKEY[1] decrements X,
//     key 3 = iKEY[2] increments Y, key 4 = iKEY[3] decrements Y.
//   Keys above 4 are debounced and produce events only.
//   Optional macro CURSOR_WRAP_EN: the position wraps at the bounds (inc past
//   MAX loads MIN, dec below MIN loads MAX). When it is undefined, the position
//   saturates at the bounds.
// Ports:
//   iCLK        system clock
//   iRST_N      asynchronous active-low reset
//   iKEY        raw keys, active-low, asynchronous to iCLK
//   iCLR        sync pulse, reloads X_CNT/Y_CNT with X_INIT/Y_INIT (beats events)
//   oKEY_LEVEL  debounced key level, 1 = pressed
//   oKEY_EVT    1-cycle step event per key (press or repeat)
//   X_CNT       X position
//   Y_CNT       Y position
module key_cursor_ctrl #(
  parameter int unsigned NUM_KEYS     = 4,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEBOUNCE_CYC = 65536,
  parameter int unsigned HOLD_CYC     = 33554432,
  parameter int unsigned REPEAT_CYC   = 262144,
  parameter int unsigned STEP         = 2,
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 32,
  parameter int unsigned X_INIT       = 16,
  parameter int unsigned Y_MIN        = 0,
  parameter int unsigned Y_MAX        = 1080,
  parameter int unsigned Y_INIT       = 540
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic [NUM_KEYS-1:0] iKEY,
  input  logic                iCLR,
  output logic [NUM_KEYS-1:0] oKEY_LEVEL,
  output logic [NUM_KEYS-1:0] oKEY_EVT,
  output logic [CNT_W-1:0]    X_CNT,
  output logic [CNT_W-1:0]    Y_CNT
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned TM_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned TM_W   = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;
  localparam int unsigned AW     = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] key_sync;
  logic [DB_W-1:0]     db_cnt [NUM_KEYS];
  rpt_state_e          state_q [NUM_KEYS];
  rpt_state_e          state_d [NUM_KEYS];
  logic [TM_W-1:0]     tmr_q [NUM_KEYS];
  logic [TM_W-1:0]     tmr_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] evt_d;

  // Two-flop synchroniser. It resets to the released (high) level.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= iKEY;
      sync2 <= sync1;
    end
  end

  assign key_sync = ~sync2;

  // Debounce: the accepted level follows the synced level only after
  // DEBOUNCE_CYC consecutive cycles of disagreement.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oKEY_LEVEL <= '0;
      for (int k = 0; k < NUM_KEYS; k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_sync[k] == oKEY_LEVEL[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_W'(DEBOUNCE_CYC - 1)) begin
          oKEY_LEVEL[k] <= key_sync[k];
          db_cnt[k]     <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Repeat FSM state register. The event output is registered here too.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oKEY_EVT <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= ST_IDLE;
        tmr_q[k]   <= '0;
      end
    end else begin
      oKEY_EVT <= evt_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= state_d[k];
        tmr_q[k]   <= tmr_d[k];
      end
    end
  end

  // Repeat FSM next state. Release wins in every state and clears the timer.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      state_d[k] = state_q[k];
      tmr_d[k]   = tmr_q[k];
      if (!oKEY_LEVEL[k]) begin
        state_d[k] = ST_IDLE;
        tmr_d[k]   = '0;
      end else begin
        case (state_q[k])
          ST_IDLE: begin
            state_d[k] = ST_DELAY;
            tmr_d[k]   = '0;
          end
          ST_DELAY: begin
            if (tmr_q[k] == TM_W'(HOLD_CYC - 1)) begin
              state_d[k] = ST_REPEAT;
              tmr_d[k]   = '0;
            end else begin
              tmr_d[k] = tmr_q[k] + TM_W'(1);
            end
          end
          ST_REPEAT: begin
            if (tmr_q[k] == TM_W'(REPEAT_CYC - 1)) tmr_d[k] = '0;
            else                                   tmr_d[k] = tmr_q[k] + TM_W'(1);
          end
          default: begin
            state_d[k] = ST_IDLE;
            tmr_d[k]   = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSM outputs: fire on the press itself, at the end of the hold
  // delay, and at the end of each repeat period.
  always_comb begin
    evt_d = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (oKEY_LEVEL[k]) begin
        case (state_q[k])
          ST_IDLE:   evt_d[k] = 1'b1;
          ST_DELAY:  evt_d[k] = (tmr_q[k] == TM_W'(HOLD_CYC - 1));
          ST_REPEAT: evt_d[k] = (tmr_q[k] == TM_W'(REPEAT_CYC - 1));
          default:   evt_d[k] = 1'b0;
        endcase
      end
    end
  end

  // Next position along one axis. The math uses one extra bit, so the
  // decrement borrow is visible even when lo is 0.
  function automatic logic [CNT_W-1:0] step_axis(
    input logic [CNT_W-1:0] cur,
    input logic             inc,
    input logic             dec,
    input logic [CNT_W-1:0] lo,
    input logic [CNT_W-1:0] hi
  );
    logic [AW-1:0] ext;
    logic [AW-1:0] sum;
    logic [AW-1:0] dif;
    logic [AW-1:0] lo_e;
    logic [AW-1:0] hi_e;
    ext  = {1'b0, cur};
    lo_e = {1'b0, lo};
    hi_e = {1'b0, hi};
    sum  = ext + AW'(STEP);
    dif  = ext - AW'(STEP);
    step_axis = cur;
    if (inc && !dec) begin
      if (sum > hi_e) begin
`ifdef CURSOR_WRAP_EN
        step_axis = lo;
`else
        step_axis = hi;
`endif
      end else begin
        step_axis = sum[CNT_W-1:0];
      end
    end else if (dec && !inc) begin
      if (dif[CNT_W] || (dif < lo_e)) begin
`ifdef CURSOR_WRAP_EN
        step_axis = hi;
`else
        step_axis = lo;
`endif
      end else begin
        step_axis = dif[CNT_W-1:0];
      end
    end
  endfunction

  // Position registers update one cycle after the step event. iCLR wins.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      X_CNT <= CNT_W'(X_INIT);
      Y_CNT <= CNT_W'(Y_INIT);
    end else if (iCLR) begin
      X_CNT <= CNT_W'(X_INIT);
      Y_CNT <= CNT_W'(Y_INIT);
    end else begin
      X_CNT <= step_axis(X_CNT, oKEY_EVT[0], oKEY_EVT[1], CNT_W'(X_MIN), CNT_W'(X_MAX));
      Y_CNT <= step_axis(Y_CNT, oKEY_EVT[2], oKEY_EVT[3], CNT_W'(Y_MIN), CNT_W'(Y_MAX));
    end
  end

endmodule
